// File: rtl/bootloader_stream.sv
// bootloader_stream: streams host boot words into a ROM write port, one lane per beat,
// with target backpressure, selectable lane order, length-based stop and running checksum.
module bootloader_stream #(
  parameter bit                    CONFIG_ON_STARTUP = 1'b1,
  parameter int unsigned           HOST_WIDTH        = 32,
  parameter int unsigned           OUT_WIDTH         = 8,
  parameter int unsigned           ADDR_WIDTH        = 19,
  parameter logic [ADDR_WIDTH-1:0] ROM_LOCATION      = ADDR_WIDTH'(32'h30000),
  parameter int unsigned           ROM_LENGTH        = 32'h2000,
  parameter bit                    BIG_ENDIAN        = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [HOST_WIDTH-1:0] host_bootdata,
  input  logic                  host_bootdata_req,
  output logic                  host_bootdata_ack,
  input  logic                  host_reset,
  output logic [OUT_WIDTH-1:0]  romwrite_data,
  output logic                  romwrite_wr,
  input  logic                  romwrite_ready,
  output logic [ADDR_WIDTH-1:0] romwrite_addr,
  output logic                  rom_initialised,
  output logic [15:0]           rom_checksum,
  output logic                  busy
);

  localparam int unsigned LANES   = HOST_WIDTH / OUT_WIDTH;
  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned COUNT_W = ADDR_WIDTH + 1;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [COUNT_W-1:0] LENGTH    = COUNT_W'(ROM_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_NEXT, S_END, S_PARKED, S_WAITRESET
  } state_t;

  state_t state_q, state_d;

  logic [COUNT_W-1:0]    count_q;
  logic [COUNT_W-1:0]    count_inc_c;
  logic [LANE_W-1:0]     lane_q;
  logic [HOST_WIDTH-1:0] shift_q;
  logic                  last_c;
  logic                  wr_d, ack_d, busy_d, init_d;

  // Lane presented first from a word, according to lane order
  function automatic logic [OUT_WIDTH-1:0] first_lane(input logic [HOST_WIDTH-1:0] w);
    if (BIG_ENDIAN) return w[HOST_WIDTH-1 -: OUT_WIDTH];
    else            return w[OUT_WIDTH-1:0];
  endfunction

  // Drop the lane just presented so the next one moves into the first-lane position
  function automatic logic [HOST_WIDTH-1:0] drop_lane(input logic [HOST_WIDTH-1:0] w);
    if (BIG_ENDIAN) return w << OUT_WIDTH;
    else            return w >> OUT_WIDTH;
  endfunction

  assign count_inc_c = count_q + COUNT_W'(1);
  assign last_c      = (lane_q == LAST_LANE) || (count_inc_c == LENGTH);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= CONFIG_ON_STARTUP ? S_IDLE : S_PARKED;
    else          state_q <= state_d;
  end

  // Next-state logic; host_reset aborts any active phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_WAIT;
      S_WAIT: begin
        if (host_reset)             state_d = S_WAITRESET;
        else if (host_bootdata_req) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (host_reset)                   state_d = S_WAITRESET;
        else if (romwrite_ready && last_c) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (host_reset)                                 state_d = S_WAITRESET;
        else if (host_bootdata_ack && !host_bootdata_req) state_d = (count_q == LENGTH) ? S_END : S_WAIT;
      end
      S_END:       state_d = S_PARKED;
      S_PARKED:    if (host_reset) state_d = S_WAITRESET;
      S_WAITRESET: if (!host_reset) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: control outputs follow the state being entered, so they register in step with it
  always_comb begin
    wr_d   = (state_d == S_WRITE);
    ack_d  = (state_d == S_NEXT);
    busy_d = wr_d || ack_d;
    init_d = rom_initialised;
    if (state_d == S_IDLE)     init_d = 1'b0;
    else if (state_d == S_END) init_d = 1'b1;
  end

  // Output registers and beat datapath (address, count, lanes, checksum)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      romwrite_wr       <= 1'b0;
      host_bootdata_ack <= 1'b0;
      busy              <= 1'b0;
      rom_initialised   <= !CONFIG_ON_STARTUP;
      romwrite_data     <= '0;
      rom_checksum      <= '0;
      romwrite_addr     <= ROM_LOCATION;
      count_q           <= '0;
      lane_q            <= '0;
      shift_q           <= '0;
    end else begin
      romwrite_wr       <= wr_d;
      host_bootdata_ack <= ack_d;
      busy              <= busy_d;
      rom_initialised   <= init_d;
      case (state_q)
        S_IDLE: begin
          romwrite_addr <= ROM_LOCATION;
          count_q       <= '0;
          lane_q        <= '0;
          rom_checksum  <= '0;
        end
        S_WAIT: begin
          if (!host_reset && host_bootdata_req) begin
            romwrite_data <= first_lane(host_bootdata);
            shift_q       <= drop_lane(host_bootdata);
            lane_q        <= '0;
          end
        end
        S_WRITE: begin
          // An accepted beat coinciding with host_reset is not accounted
          if (!host_reset && romwrite_ready) begin
            romwrite_addr <= romwrite_addr + ADDR_WIDTH'(1);
            count_q       <= count_inc_c;
            rom_checksum  <= rom_checksum + 16'(romwrite_data);
            lane_q        <= lane_q + LANE_W'(1);
            if (!last_c) begin
              romwrite_data <= first_lane(shift_q);
              shift_q       <= drop_lane(shift_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bootloader_stream.sv
// Self-checking bench for bootloader_stream: four instances (big endian, little endian,
// short ROM_LENGTH, parked at startup) share stimulus; each test observes one of them.
module tb_bootloader_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] din;
  logic        req, hr, ready;

  logic        be_ack, be_wr, be_init, be_busy;
  logic [7:0]  be_data;
  logic [18:0] be_addr;
  logic [15:0] be_csum;
  logic        le_ack, le_wr, le_init, le_busy;
  logic [7:0]  le_data;
  logic [18:0] le_addr;
  logic [15:0] le_csum;
  logic        len_ack, len_wr, len_init, len_busy;
  logic [7:0]  len_data;
  logic [18:0] len_addr;
  logic [15:0] len_csum;
  logic        pk_ack, pk_wr, pk_init, pk_busy;
  logic [7:0]  pk_data;
  logic [18:0] pk_addr;
  logic [15:0] pk_csum;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bootloader_stream u_be (
    .clk(clk), .reset_n(reset_n), .host_bootdata(din), .host_bootdata_req(req),
    .host_bootdata_ack(be_ack), .host_reset(hr), .romwrite_data(be_data), .romwrite_wr(be_wr),
    .romwrite_ready(ready), .romwrite_addr(be_addr), .rom_initialised(be_init),
    .rom_checksum(be_csum), .busy(be_busy));

  bootloader_stream #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset_n(reset_n), .host_bootdata(din), .host_bootdata_req(req),
    .host_bootdata_ack(le_ack), .host_reset(hr), .romwrite_data(le_data), .romwrite_wr(le_wr),
    .romwrite_ready(ready), .romwrite_addr(le_addr), .rom_initialised(le_init),
    .rom_checksum(le_csum), .busy(le_busy));

  bootloader_stream #(.ROM_LENGTH(6)) u_len (
    .clk(clk), .reset_n(reset_n), .host_bootdata(din), .host_bootdata_req(req),
    .host_bootdata_ack(len_ack), .host_reset(hr), .romwrite_data(len_data), .romwrite_wr(len_wr),
    .romwrite_ready(ready), .romwrite_addr(len_addr), .rom_initialised(len_init),
    .rom_checksum(len_csum), .busy(len_busy));

  bootloader_stream #(.CONFIG_ON_STARTUP(1'b0)) u_pk (
    .clk(clk), .reset_n(reset_n), .host_bootdata(din), .host_bootdata_req(req),
    .host_bootdata_ack(pk_ack), .host_reset(hr), .romwrite_data(pk_data), .romwrite_wr(pk_wr),
    .romwrite_ready(ready), .romwrite_addr(pk_addr), .rom_initialised(pk_init),
    .rom_checksum(pk_csum), .busy(pk_busy));

  // Beat monitors: accepted transfers seen at the target
  logic        mon_clr;
  int          be_beats, len_beats;
  logic        len_bad;
  logic [7:0]  len_last_data;
  logic [18:0] len_last_addr;

  always @(posedge clk) begin
    if (mon_clr) begin
      be_beats <= 0; len_beats <= 0; len_bad <= 1'b0;
      len_last_data <= '0; len_last_addr <= '0;
    end else begin
      if (be_wr && ready) be_beats <= be_beats + 1;
      if (len_wr && ready) begin
        len_beats     <= len_beats + 1;
        len_last_data <= len_data;
        len_last_addr <= len_addr;
        if (len_data == 8'h07 || len_data == 8'h08) len_bad <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        req;
    logic        ready;
    logic        exp_wr;
    logic        exp_ack;
    logic [18:0] exp_addr;
    logic [7:0]  exp_be;
    logic [7:0]  exp_le;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      0:       return be_ack;
      1:       return le_ack;
      2:       return len_ack;
      default: return pk_ack;
    endcase
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = 1'b0; hr = 1'b0; ready = 1'b1; din = '0;
    tick(); tick();
    chk("rst_wr", be_wr, 1'b0);
    chk("rst_ack", be_ack, 1'b0);
    chk("rst_data", be_data, 8'h00);
    chk("rst_csum", be_csum, 16'h0);
    chk("rst_busy", be_busy, 1'b0);
    chk("rst_init_armed", be_init, 1'b0);
    chk("rst_init_parked", pk_init, 1'b1);
    reset_n = 1'b1;
    tick();
  endtask

  // Wait for ack, drop req, wait for ack release
  task automatic finish_word(input int which);
    int n;
    n = 0;
    while (ack_of(which) !== 1'b1 && n < 40) begin tick(); n++; end
    chk("ack_rise", ack_of(which), 1'b1);
    req = 1'b0;
    tick();
    n = 0;
    while (ack_of(which) !== 1'b0 && n < 40) begin tick(); n++; end
    chk("ack_fall", ack_of(which), 1'b0);
  endtask

  task automatic send_word(input int which, input logic [31:0] w);
    din = w;
    req = 1'b1;
    finish_word(which);
  endtask

  initial begin
    mon_clr = 1'b0;
    // Tests 1/2: one word through both lane orders, cycle by cycle
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h30000, 8'h11, 8'h44};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h30001, 8'h22, 8'h33};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h30002, 8'h33, 8'h22};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h30003, 8'h44, 8'h11};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 19'h30004, 8'h44, 8'h11};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 19'h30004, 8'h44, 8'h11};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h30004, 8'h44, 8'h11};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h30004, 8'h44, 8'h11};

    do_reset();
    din = 32'h11223344;
    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req;
      ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d_be_wr", i), be_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d_le_wr", i), le_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d_be_ack", i), be_ack, vecs[i].exp_ack);
      chk($sformatf("v%0d_le_ack", i), le_ack, vecs[i].exp_ack);
      chk($sformatf("v%0d_be_addr", i), be_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_le_addr", i), le_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_be_busy", i), be_busy, vecs[i].exp_wr | vecs[i].exp_ack);
      if (vecs[i].exp_wr) begin
        chk($sformatf("v%0d_be_data", i), be_data, vecs[i].exp_be);
        chk($sformatf("v%0d_le_data", i), le_data, vecs[i].exp_le);
      end
    end
    chk("t1_be_csum", be_csum, 16'h00AA);
    chk("t2_le_csum", le_csum, 16'h00AA);

    // Test 3: backpressure on lane 2
    do_reset();
    clear_mon();
    din = 32'h11223344; req = 1'b1; ready = 1'b1;
    tick(); tick(); tick();
    chk("t3_pre_data", be_data, 8'h33);
    chk("t3_pre_addr", be_addr, 19'h30002);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_stall%0d_wr", k), be_wr, 1'b1);
      chk($sformatf("t3_stall%0d_data", k), be_data, 8'h33);
      chk($sformatf("t3_stall%0d_addr", k), be_addr, 19'h30002);
      chk($sformatf("t3_stall%0d_ack", k), be_ack, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk("t3_lane3_data", be_data, 8'h44);
    chk("t3_lane3_addr", be_addr, 19'h30003);
    chk("t3_lane3_ack", be_ack, 1'b0);
    tick();
    chk("t3_ack", be_ack, 1'b1);
    chk("t3_wr_low", be_wr, 1'b0);
    chk("t3_beats", be_beats, 4);
    req = 1'b0;
    tick();
    chk("t3_ack_drop", be_ack, 1'b0);

    // Test 4: length-based termination mid-word
    do_reset();
    clear_mon();
    send_word(2, 32'h01020304);
    chk("t4_init_mid", len_init, 1'b0);
    send_word(2, 32'h05060708);
    tick(); tick();
    chk("t4_init", len_init, 1'b1);
    chk("t4_csum", len_csum, 16'h0015);
    chk("t4_beats", len_beats, 6);
    chk("t4_last_data", len_last_data, 8'h06);
    chk("t4_last_addr", len_last_addr, 19'h30005);
    chk("t4_no_07_08", len_bad, 1'b0);
    din = 32'hDEADBEEF; req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_ign%0d_wr", k), len_wr, 1'b0);
      chk($sformatf("t4_ign%0d_ack", k), len_ack, 1'b0);
    end
    req = 1'b0;
    chk("t4_beats_after", len_beats, 6);

    // Test 5: host_reset after two beats
    do_reset();
    din = 32'h11223344; req = 1'b1; ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_pre_data", be_data, 8'h33);
    hr = 1'b1; req = 1'b0;
    tick();
    chk("t5_abort_wr", be_wr, 1'b0);
    chk("t5_abort_ack", be_ack, 1'b0);
    chk("t5_abort_busy", be_busy, 1'b0);
    tick();
    hr = 1'b0;
    tick(); tick();
    chk("t5_csum_clr", be_csum, 16'h0);
    chk("t5_init", be_init, 1'b0);
    chk("t5_addr", be_addr, 19'h30000);
    din = 32'hA1B2C3D4; req = 1'b1;
    tick();
    chk("t5_first_wr", be_wr, 1'b1);
    chk("t5_first_data", be_data, 8'hA1);
    chk("t5_first_addr", be_addr, 19'h30000);
    finish_word(0);
    chk("t5_csum", be_csum, 16'h02EA);

    // Test 6: parked at startup, re-armed by host_reset
    do_reset();
    chk("t6_init", pk_init, 1'b1);
    chk("t6_wr", pk_wr, 1'b0);
    din = 32'h11223344; req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_ign%0d_wr", k), pk_wr, 1'b0);
      chk($sformatf("t6_ign%0d_ack", k), pk_ack, 1'b0);
    end
    req = 1'b0;
    hr = 1'b1;
    tick();
    hr = 1'b0;
    tick(); tick();
    chk("t6_rearm_init", pk_init, 1'b0);
    req = 1'b1;
    tick();
    chk("t6_first_wr", pk_wr, 1'b1);
    chk("t6_first_data", pk_data, 8'h11);
    chk("t6_first_addr", pk_addr, 19'h30000);
    finish_word(3);
    chk("t6_csum", pk_csum, 16'h00AA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
